// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int NFLAGS = 4;

  // Two's-complement overflow of an addition, from the operand and sum sign bits.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for every single-cycle op; MUL is handled by the sequential wrapper.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic [NFLAGS-1:0] flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;

  always_comb begin
    b_eff  = (op == OP_SUB) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    sh     = b[SHW-1:0];
    // One guard bit beside the operand catches the last bit shifted out.
    shl_w  = {1'b0, a} << sh;
    shr_w  = {a, 1'b0} >> sh;
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        result         = sum[WIDTH-1:0];
        flags[FLAG_C]  = sum[WIDTH];
        flags[FLAG_V]  = add_ovf(a[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result        = shl_w[WIDTH-1:0];
        flags[FLAG_C] = shl_w[WIDTH];
      end
      OP_SHR: begin
        result        = shr_w[WIDTH:1];
        flags[FLAG_C] = shr_w[0];
      end
      default: result = '0;
    endcase
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU between register read and write-back; single-cycle ops plus a shift-add MUL.
//   state   | meaning
//   IDLE    | empty, ready for a new op
//   MUL     | shift-add multiply in progress, cnt steps remaining, inputs ignored
//   DONE    | result/flags valid, held until out_ready
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW = SHW + 1;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mcand, mplier, acc;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]  core_result;
  logic [NFLAGS-1:0] core_flags;
  logic              accept, mul_last;

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (core_result),
    .flags  (core_flags)
  );

  assign in_ready  = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign mul_last  = (state == ST_MUL) && (cnt == CW'(1));

  // Low product bits shift into mplier as its consumed bits drop out the bottom.
  assign mul_sum   = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign prod_next = {mul_sum, mplier[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (op == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_last) state_next = ST_DONE;
      ST_DONE: begin
        if (accept)         state_next = (op == OP_MUL) ? ST_MUL : ST_DONE;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      result    <= '0;
      result_hi <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else begin
        result    <= core_result;
        result_hi <= '0;
        flag_c    <= core_flags[FLAG_C];
        flag_z    <= core_flags[FLAG_Z];
        flag_n    <= core_flags[FLAG_N];
        flag_v    <= core_flags[FLAG_V];
      end
    end else if (state == ST_MUL) begin
      acc    <= prod_next[2*WIDTH-1:WIDTH];
      mplier <= prod_next[WIDTH-1:0];
      cnt    <= cnt - CW'(1);
      if (mul_last) begin
        result    <= prod_next[WIDTH-1:0];
        result_hi <= prod_next[2*WIDTH-1:WIDTH];
        flag_c    <= |prod_next[2*WIDTH-1:WIDTH];
        flag_z    <= (prod_next == '0);
        flag_n    <= prod_next[2*WIDTH-1];
        flag_v    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=16: directed table, handshake sequences, random scoreboard.
module tb_alu_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    op;
  logic [W-1:0]  a, b, result, result_hi;
  logic          flag_c, flag_z, flag_n, flag_v;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] res;
    logic c, z, n, v;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
    int          wait_cyc;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[16];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [15:0] h, input logic [15:0] r,
                              input logic c, input logic z, input logic n, input logic v);
    return {h, r, c, z, n, v};
  endfunction

  function automatic exp_t got();
    return {result_hi, result, flag_c, flag_z, flag_n, flag_v};
  endfunction

  // Reference model written from the arithmetic definition of each op.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t   e;
    longint ux, uy, full;
    int     s, sx, sy, ss;
    e    = '0;
    ux   = longint'(x);
    uy   = longint'(y);
    s    = int'(y[3:0]);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    full = 0;
    case (o)
      3'd0: begin
        full  = ux + uy;
        e.res = 16'(full);
        e.c   = (full > 65535);
        ss    = sx + sy;
        e.v   = (ss > 32767) || (ss < -32768);
      end
      3'd1: begin
        full  = ux - uy;
        e.res = 16'(full);
        e.c   = (ux >= uy);
        ss    = sx - sy;
        e.v   = (ss > 32767) || (ss < -32768);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: begin
        e.res = 16'(ux << s);
        e.c   = (s != 0) && (((ux >> (16 - s)) & 1) == 1);
      end
      3'd6: begin
        e.res = 16'(ux >> s);
        e.c   = (s != 0) && (((ux >> (s - 1)) & 1) == 1);
      end
      default: begin
        full  = ux * uy;
        e.res = 16'(full);
        e.hi  = 16'(full >> 16);
        e.c   = (e.hi != 0);
      end
    endcase
    if (o == 3'd7) begin
      e.z = (full == 0);
      e.n = e.hi[15];
    end else begin
      e.z = (e.res == 0);
      e.n = e.res[15];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0: begin
        case ($urandom_range(0, 3))
          0: return 16'hFFFF;
          1: return 16'h8000;
          2: return 16'h0000;
          default: return 16'h0001;
        endcase
      end
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid with no outstanding op, got %h expected none", name, got());
    end else begin
      e = sbq.pop_front();
      check(name, got(), e);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int  wc, busy;
    bit  seen;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({name, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; a = '0; b = '0;
    wc = 0; busy = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (in_ready) busy++;
      wc++;
    end
    check({name, " out_valid seen"}, seen, 1);
    check({name, " wait cycles"}, wc, v.wait_cyc);
    check({name, " in_ready during op"}, busy, 0);
    check({name, " result"}, got(), v.e);
  endtask

  function automatic logic [15:0] b2b_exp(input int i);
    return 16'(100 * i + 1) + 16'(i + 7);
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;

    vt[0]  = '{3'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0000, 1, 1, 0, 0), 0};
    vt[1]  = '{3'd1, 16'h8000, 16'h0001, mk(16'h0000, 16'h7FFF, 1, 0, 0, 1), 0};
    vt[2]  = '{3'd1, 16'h0001, 16'h0002, mk(16'h0000, 16'hFFFF, 0, 0, 1, 0), 0};
    vt[3]  = '{3'd5, 16'h8001, 16'h0011, mk(16'h0000, 16'h0002, 1, 0, 0, 0), 0};
    vt[4]  = '{3'd6, 16'h0003, 16'h0000, mk(16'h0000, 16'h0003, 0, 0, 0, 0), 0};
    vt[5]  = '{3'd7, 16'hFFFF, 16'hFFFF, mk(16'hFFFE, 16'h0001, 1, 0, 1, 0), 16};
    vt[6]  = '{3'd7, 16'h00FF, 16'h0101, mk(16'h0000, 16'hFFFF, 0, 0, 0, 0), 16};
    vt[7]  = '{3'd0, 16'h7FFF, 16'h0001, mk(16'h0000, 16'h8000, 0, 0, 1, 1), 0};
    vt[8]  = '{3'd2, 16'hF0F0, 16'h0FF0, mk(16'h0000, 16'h00F0, 0, 0, 0, 0), 0};
    vt[9]  = '{3'd3, 16'h1200, 16'h0034, mk(16'h0000, 16'h1234, 0, 0, 0, 0), 0};
    vt[10] = '{3'd4, 16'hAAAA, 16'hAAAA, mk(16'h0000, 16'h0000, 0, 1, 0, 0), 0};
    vt[11] = '{3'd6, 16'h8000, 16'h000F, mk(16'h0000, 16'h0001, 0, 0, 0, 0), 0};
    vt[12] = '{3'd6, 16'h0003, 16'h0001, mk(16'h0000, 16'h0001, 1, 0, 0, 0), 0};
    vt[13] = '{3'd5, 16'h1234, 16'h0010, mk(16'h0000, 16'h1234, 0, 0, 0, 0), 0};
    vt[14] = '{3'd7, 16'h0000, 16'h1234, mk(16'h0000, 16'h0000, 0, 1, 0, 0), 16};
    vt[15] = '{3'd1, 16'h0005, 16'h0005, mk(16'h0000, 16'h0000, 1, 1, 0, 0), 0};

    // Reset state
    @(negedge clk);
    #1 check("reset outputs", {out_valid, in_ready, got()}, '0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post-reset ready", {in_ready, out_valid}, 2'b10);

    // Directed table
    for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Back-to-back ADDs, then backpressure
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 16'(1); b = 16'(7);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      a = 16'(100 * i + 1); b = 16'(i + 7);
      #1 check($sformatf("b2b out%0d", i - 1), {out_valid, result}, {1'b1, b2b_exp(i - 1)});
    end
    @(negedge clk);
    a = 16'(401); b = 16'(11); out_ready = 1'b0;
    #1 check("stall 0", {out_valid, result, in_ready}, {1'b1, b2b_exp(3), 1'b0});
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("stall %0d", i), {out_valid, result, in_ready}, {1'b1, b2b_exp(3), 1'b0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("stall release", {out_valid, result, in_ready}, {1'b1, b2b_exp(3), 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("held op out", {out_valid, result}, {1'b1, b2b_exp(4)});
    @(negedge clk);
    #1 check("b2b drained", out_valid, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 3'd7; a = 16'h1234; b = 16'h00FF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async reset mid-mul", {out_valid, in_ready, got()}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("ready after reset", {in_ready, out_valid}, 2'b10);
    begin
      int spurious;
      spurious = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_valid) spurious++;
      end
      check("aborted mul silent", spurious, 0);
    end
    run_vec('{3'd0, 16'h0002, 16'h0003, mk(16'h0000, 16'h0005, 0, 0, 0, 0), 0}, "add after reset");

    // Random traffic against the scoreboard
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 6));
      a = pick();
      b = pick();
      #1;
      if (out_valid && out_ready) pop_check("random");
      if (in_valid && in_ready) sbq.push_back(model(op, a, b));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (out_valid) pop_check("drain");
      @(negedge clk);
    end
    check("scoreboard empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 16-bit ripple add/sub/and/or ALU.
- Width is generalised. The op set grows to 8 ops, adding XOR, both shifts and a multi-cycle unsigned shift-add multiply.
- Operands are registered, and the block produces status flags (C/Z/N/V).
- Sits between the register-file read stage and write-back, using valid/ready on both sides.

Parameters:
- WIDTH, 16, operand/result width. Must be a power of two, at least 4.
- SHW, $clog2(WIDTH), derived. Number of b bits used as the shift amount.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  op/a/b valid
- in_ready  output  1  block can accept a new op this cycle
- op  input  3  operation code (see Behaviour)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0])
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  result; low half of the product for MUL
- result_hi  output  WIDTH  high half of the product for MUL; 0 for all other ops
- flag_c  output  1  carry / no-borrow / shifted-out bit / mul-high-nonzero
- flag_z  output  1  result zero (full 2*WIDTH product for MUL)
- flag_n  output  1  result[WIDTH-1] (result_hi[WIDTH-1] for MUL)
- flag_v  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset is asynchronous and active-high.
  - All registered outputs clear to 0, and state goes to IDLE.
  - in_ready is 0 while reset is asserted and 1 on the first cycle after deassert.
  - Reset mid-MUL aborts the multiply; no result is emitted.
- Op codes:
  - 000 ADD: a+b. C = carry out.
  - 001 SUB: a+~b+1. C = carry out (1 means a >= b unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a << b[SHW-1:0]. C = last bit shifted out; 0 if the amount is 0.
  - 110 SHR logical: a >> b[SHW-1:0]. C = last bit shifted out; 0 if the amount is 0.
  - 111 MUL: unsigned WIDTH x WIDTH -> 2*WIDTH. C = (result_hi != 0).
- Flag rules:
  - V = sign(a)==sign(b') && sign(sum)!=sign(a), where b' = b for ADD and ~b for SUB. V = 0 for all other ops.
  - C = 0 for logical ops.
  - Upper b bits beyond SHW are ignored for shifts.
- State machine (IDLE, MUL, DONE):
  - An op is accepted on a rising edge where in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Single-cycle ops: result and flags are registered on the accept edge, and the next state is DONE. Latency is 1 cycle (out_valid is high in the cycle after the accept edge).
  - MUL on accept:
    - Latch a into mcand and b into mplier.
    - Clear the accumulator and set cnt = WIDTH.
    - Next state is MUL.
  - In MUL, each edge performs one step:
    - If mplier[0], add mcand into acc[2W-1:W] with carry.
    - Shift {carry, acc, mplier} right by 1.
    - Decrement cnt.
    - When the step with cnt==1 completes, load the outputs and go to DONE.
    - MUL latency is WIDTH cycles from the accept edge to out_valid.
  - out_valid = (state==DONE).
  - Outputs hold stable while out_valid && !out_ready; the backpressure is indefinite.
  - In DONE with out_ready:
    - If a new op is simultaneously accepted, its path is taken (DONE, or MUL).
    - Otherwise the state returns to IDLE.
  - This gives a sustained throughput of 1 op/cycle for non-MUL ops.
  - in_ready is 0 throughout MUL; inputs are ignored.
- Outputs are registered. result/result_hi/flags keep their last value after out_valid falls. Consumers only sample them with out_valid.

Decomposition:
- Shared package alu_pkg holds:
  - the op code localparams (OP_ADD .. OP_MUL);
  - the state encoding (ST_IDLE, ST_MUL, ST_DONE);
  - the flag-bit index constants.
- Sub-module alu_core is purely combinational.
  - It takes (op, a, b) and returns the WIDTH result plus C/Z/N/V for all single-cycle ops.
  - alu_pipe instantiates it and owns the FSM, the handshake and the MUL shift-add datapath.

Test Plan (WIDTH=16):
- ADD a=0xFFFF b=0x0001 -> one cycle later out_valid=1, result=0x0000, C=1 Z=1 N=0 V=0, result_hi=0.
- SUB a=0x8000 b=0x0001 -> result=0x7FFF, C=1 V=1 N=0. Also SUB a=0x0001 b=0x0002 -> result=0xFFFF, C=0 N=1 V=0.
- SHL a=0x8001 b=0x0011 (amount 1) -> result=0x0002, C=1. SHR a=0x0003 b=0x0000 -> result=0x0003, C=0.
- MUL a=0xFFFF b=0xFFFF -> in_ready=0 for 16 cycles, then out_valid at accept+16 with result=0x0001, result_hi=0xFFFE, C=1 N=1 Z=0. MUL 0x00FF*0x0101 -> result=0xFFFF, hi=0x0000, C=0.
- Back-to-back: 4 ADDs presented every cycle with out_ready=1 -> 4 results on 4 consecutive cycles, in order. Then hold out_ready=0 for 3 cycles -> result stable, in_ready=0, no op lost.
- Assert reset 5 cycles into a MUL -> all outputs 0 immediately (async). After release, in_ready=1, out_valid stays 0, and a following ADD 2+3 returns 0x0005.
